// File: rtl/pipeline_hazard_ctrl.sv
// Decode-stage sequencing controller: load-use bubbles, multi-cycle redirect
// flushes, memory-busy freeze and saturating stall/flush counters.
module pipeline_hazard_ctrl #(
   parameter int REG_ADDR_WIDTH = 5,
   parameter int FLUSH_CYCLES   = 2,
   parameter int CNT_WIDTH      = 16
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      id_ex_mem_data_rd_en,
   input  logic [REG_ADDR_WIDTH-1:0] id_ex_reg_wr_addr,
   input  logic                      if_id_rd_reg_a_en,
   input  logic                      if_id_rd_reg_b_en,
   input  logic [REG_ADDR_WIDTH-1:0] if_id_rd_reg_a_addr,
   input  logic [REG_ADDR_WIDTH-1:0] if_id_rd_reg_b_addr,
   input  logic                      select_new_pc,
   input  logic                      mem_busy,
   input  logic                      counters_clr,
   output logic                      inst_rd_en,
   output logic                      stall,
   output logic                      decode_flush,
   output logic                      general_flush,
   output logic [CNT_WIDTH-1:0]      stall_count,
   output logic [CNT_WIDTH-1:0]      flush_count,
   output logic [1:0]                state_out
);

   localparam int FCW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
   localparam logic [FCW-1:0] CNT_RELOAD = FCW'(FLUSH_CYCLES - 1);
   localparam bit MULTI_FLUSH = (FLUSH_CYCLES > 1);

   typedef enum logic [1:0] {
      ST_RUN      = 2'b00,
      ST_FLUSH    = 2'b01,
      ST_MEM_WAIT = 2'b10,
      ST_BAD      = 2'b11
   } state_e;

   state_e               state_q, state_d;
   logic [FCW-1:0]       cnt_q, cnt_d;
   logic                 pending_q, pending_d;
   logic [CNT_WIDTH-1:0] stall_count_q, stall_count_d;
   logic [CNT_WIDTH-1:0] flush_count_q, flush_count_d;

   logic hazard;
   logic run_act;
   logic redirect;
   logic flush_inc;
   logic inst_rd_en_c, stall_c, decode_flush_c, general_flush_c;

   assign hazard = id_ex_mem_data_rd_en && (id_ex_reg_wr_addr != '0) &&
                   ((if_id_rd_reg_a_en && (if_id_rd_reg_a_addr == id_ex_reg_wr_addr)) ||
                    (if_id_rd_reg_b_en && (if_id_rd_reg_b_addr == id_ex_reg_wr_addr)));

   always_comb begin
      state_d         = state_q;
      cnt_d           = cnt_q;
      pending_d       = pending_q;
      run_act         = 1'b0;
      redirect        = 1'b0;
      flush_inc       = 1'b0;
      inst_rd_en_c    = 1'b0;
      stall_c         = 1'b0;
      decode_flush_c  = 1'b0;
      general_flush_c = 1'b0;

      case (state_q)
         ST_RUN: begin
            run_act  = 1'b1;
            redirect = select_new_pc;
         end
         ST_FLUSH: begin
            if (mem_busy) begin
               // Freeze; the rest of this flush is replayed once memory completes.
               stall_c   = 1'b1;
               pending_d = 1'b1;
               state_d   = ST_MEM_WAIT;
            end else begin
               inst_rd_en_c    = 1'b1;
               decode_flush_c  = 1'b1;
               general_flush_c = 1'b1;
               if (select_new_pc) begin
                  flush_inc = 1'b1;
                  cnt_d     = CNT_RELOAD;
                  state_d   = MULTI_FLUSH ? ST_FLUSH : ST_RUN;
               end else begin
                  cnt_d = cnt_q - FCW'(1);
                  if (cnt_q <= FCW'(1)) state_d = ST_RUN;
               end
            end
         end
         ST_MEM_WAIT: begin
            if (mem_busy) begin
               stall_c = 1'b1;
               if (select_new_pc) pending_d = 1'b1;
            end else begin
               run_act   = 1'b1;
               redirect  = select_new_pc || pending_q;
               pending_d = 1'b0;
            end
         end
         default: begin
            state_d   = ST_RUN;
            cnt_d     = '0;
            pending_d = 1'b0;
         end
      endcase

      // Shared RUN decision, also used on the cycle memory releases MEM_WAIT.
      if (run_act) begin
         if (mem_busy) begin
            stall_c   = 1'b1;
            pending_d = select_new_pc;
            state_d   = ST_MEM_WAIT;
         end else if (redirect) begin
            inst_rd_en_c    = 1'b1;
            decode_flush_c  = 1'b1;
            general_flush_c = 1'b1;
            flush_inc       = 1'b1;
            cnt_d           = CNT_RELOAD;
            state_d         = MULTI_FLUSH ? ST_FLUSH : ST_RUN;
         end else if (hazard) begin
            stall_c        = 1'b1;
            decode_flush_c = 1'b1;
            state_d        = ST_RUN;
         end else begin
            inst_rd_en_c = 1'b1;
            state_d      = ST_RUN;
         end
      end
   end

   always_comb begin
      stall_count_d = stall_count_q;
      flush_count_d = flush_count_q;
      if (counters_clr) begin
         stall_count_d = '0;
         flush_count_d = '0;
      end else begin
         if (stall_c && (stall_count_q != '1)) stall_count_d = stall_count_q + 1'b1;
         if (flush_inc && (flush_count_q != '1)) flush_count_d = flush_count_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= ST_RUN;
         cnt_q         <= '0;
         pending_q     <= 1'b0;
         stall_count_q <= '0;
         flush_count_q <= '0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         pending_q     <= pending_d;
         stall_count_q <= stall_count_d;
         flush_count_q <= flush_count_d;
      end
   end

   // Reset forces the pipeline controls quiet without waiting for a clock.
   assign inst_rd_en    = rst_n && inst_rd_en_c;
   assign stall         = rst_n && stall_c;
   assign decode_flush  = rst_n && decode_flush_c;
   assign general_flush = rst_n && general_flush_c;
   assign stall_count   = stall_count_q;
   assign flush_count   = flush_count_q;
   assign state_out     = state_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl: inputs change on the falling edge,
// outputs are compared 1 ns later against hand-computed values.
module tb_pipeline_hazard_ctrl;

   logic        clk;
   logic        rst_n;
   logic        id_ex_mem_data_rd_en;
   logic [4:0]  id_ex_reg_wr_addr;
   logic        if_id_rd_reg_a_en;
   logic        if_id_rd_reg_b_en;
   logic [4:0]  if_id_rd_reg_a_addr;
   logic [4:0]  if_id_rd_reg_b_addr;
   logic        select_new_pc;
   logic        mem_busy;
   logic        counters_clr;
   logic        inst_rd_en;
   logic        stall;
   logic        decode_flush;
   logic        general_flush;
   logic [15:0] stall_count;
   logic [15:0] flush_count;
   logic [1:0]  state_out;

   int checks = 0;
   int errors = 0;

   pipeline_hazard_ctrl #(
      .REG_ADDR_WIDTH(5),
      .FLUSH_CYCLES  (2),
      .CNT_WIDTH     (16)
   ) dut (
      .clk                 (clk),
      .rst_n               (rst_n),
      .id_ex_mem_data_rd_en(id_ex_mem_data_rd_en),
      .id_ex_reg_wr_addr   (id_ex_reg_wr_addr),
      .if_id_rd_reg_a_en   (if_id_rd_reg_a_en),
      .if_id_rd_reg_b_en   (if_id_rd_reg_b_en),
      .if_id_rd_reg_a_addr (if_id_rd_reg_a_addr),
      .if_id_rd_reg_b_addr (if_id_rd_reg_b_addr),
      .select_new_pc       (select_new_pc),
      .mem_busy            (mem_busy),
      .counters_clr        (counters_clr),
      .inst_rd_en          (inst_rd_en),
      .stall               (stall),
      .decode_flush        (decode_flush),
      .general_flush       (general_flush),
      .stall_count         (stall_count),
      .flush_count         (flush_count),
      .state_out           (state_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // inst_rd_en, stall, decode_flush, general_flush in one go
   task automatic chk_ctl(input string tag, input logic i, input logic s,
                          input logic d, input logic g);
      chk({tag, ".inst_rd_en"}, 32'(inst_rd_en), 32'(i));
      chk({tag, ".stall"}, 32'(stall), 32'(s));
      chk({tag, ".decode_flush"}, 32'(decode_flush), 32'(d));
      chk({tag, ".general_flush"}, 32'(general_flush), 32'(g));
   endtask

   task automatic idle();
      id_ex_mem_data_rd_en = 1'b0;
      id_ex_reg_wr_addr    = '0;
      if_id_rd_reg_a_en    = 1'b0;
      if_id_rd_reg_b_en    = 1'b0;
      if_id_rd_reg_a_addr  = '0;
      if_id_rd_reg_b_addr  = '0;
      select_new_pc        = 1'b0;
      mem_busy             = 1'b0;
      counters_clr         = 1'b0;
   endtask

   // advance to the next falling edge and return everything to idle
   task automatic next_cycle();
      @(negedge clk);
      idle();
   endtask

   task automatic settle();
      #1;
   endtask

   initial begin
      rst_n = 1'b0;
      idle();

      // reset
      @(negedge clk);
      settle();
      chk("rst.state", 32'(state_out), 32'h0);
      chk_ctl("rst", 1'b0, 1'b0, 1'b0, 1'b0);
      chk("rst.stall_count", 32'(stall_count), 32'h0);
      chk("rst.flush_count", 32'(flush_count), 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      settle();
      chk_ctl("run_idle", 1'b1, 1'b0, 1'b0, 1'b0);

      // 1) load r5 in EX, decode reads A=r5: one bubble
      next_cycle();
      id_ex_mem_data_rd_en = 1'b1; id_ex_reg_wr_addr = 5'd5;
      if_id_rd_reg_a_en = 1'b1; if_id_rd_reg_a_addr = 5'd5;
      settle();
      chk_ctl("t1.hazard", 1'b0, 1'b1, 1'b1, 1'b0);
      chk("t1.state", 32'(state_out), 32'h0);
      next_cycle();
      settle();
      chk_ctl("t1.after", 1'b1, 1'b0, 1'b0, 1'b0);
      chk("t1.stall_count", 32'(stall_count), 32'h1);

      // 2) r0 load never stalls; disabled B port never stalls; enabled B port does
      next_cycle();
      id_ex_mem_data_rd_en = 1'b1; id_ex_reg_wr_addr = 5'd0;
      if_id_rd_reg_a_en = 1'b1; if_id_rd_reg_a_addr = 5'd0;
      settle();
      chk_ctl("t2.r0", 1'b1, 1'b0, 1'b0, 1'b0);
      next_cycle();
      id_ex_mem_data_rd_en = 1'b1; id_ex_reg_wr_addr = 5'd7;
      if_id_rd_reg_b_en = 1'b0; if_id_rd_reg_b_addr = 5'd7;
      if_id_rd_reg_a_en = 1'b1; if_id_rd_reg_a_addr = 5'd6;
      settle();
      chk_ctl("t2.b_dis", 1'b1, 1'b0, 1'b0, 1'b0);
      next_cycle();
      id_ex_mem_data_rd_en = 1'b1; id_ex_reg_wr_addr = 5'd7;
      if_id_rd_reg_b_en = 1'b1; if_id_rd_reg_b_addr = 5'd7;
      settle();
      chk_ctl("t2.b_en", 1'b0, 1'b1, 1'b1, 1'b0);
      next_cycle();
      settle();
      chk("t2.stall_count", 32'(stall_count), 32'h2);

      // 3) redirect: two flush cycles, then a second pulse inside FLUSH extends it
      next_cycle();
      select_new_pc = 1'b1;
      settle();
      chk_ctl("t3.pulse", 1'b1, 1'b0, 1'b1, 1'b1);
      chk("t3.pulse.state", 32'(state_out), 32'h0);
      next_cycle();
      settle();
      chk("t3.flush.state", 32'(state_out), 32'h1);
      chk_ctl("t3.flush", 1'b1, 1'b0, 1'b1, 1'b1);
      chk("t3.flush_count", 32'(flush_count), 32'h1);
      next_cycle();
      settle();
      chk("t3.back.state", 32'(state_out), 32'h0);
      chk_ctl("t3.back", 1'b1, 1'b0, 1'b0, 1'b0);
      select_new_pc = 1'b1;
      settle();
      chk("t3.p2a.gflush", 32'(general_flush), 32'h1);
      next_cycle();
      select_new_pc = 1'b1;
      settle();
      chk("t3.p2b.state", 32'(state_out), 32'h1);
      chk("t3.p2b.gflush", 32'(general_flush), 32'h1);
      chk("t3.p2b.flush_count", 32'(flush_count), 32'h2);
      next_cycle();
      settle();
      chk("t3.ext.state", 32'(state_out), 32'h1);
      chk("t3.ext.gflush", 32'(general_flush), 32'h1);
      chk("t3.ext.flush_count", 32'(flush_count), 32'h3);
      next_cycle();
      settle();
      chk("t3.end.state", 32'(state_out), 32'h0);
      chk("t3.end.gflush", 32'(general_flush), 32'h0);

      // clear wins over a simultaneous stall increment
      id_ex_mem_data_rd_en = 1'b1; id_ex_reg_wr_addr = 5'd3;
      if_id_rd_reg_a_en = 1'b1; if_id_rd_reg_a_addr = 5'd3;
      counters_clr = 1'b1;
      settle();
      chk("clr.stall", 32'(stall), 32'h1);
      next_cycle();
      settle();
      chk("clr.stall_count", 32'(stall_count), 32'h0);
      chk("clr.flush_count", 32'(flush_count), 32'h0);

      // 4) mem_busy for 3 cycles, redirect in the second, replayed afterwards
      next_cycle();
      mem_busy = 1'b1;
      settle();
      chk_ctl("t4.c1", 1'b0, 1'b1, 1'b0, 1'b0);
      chk("t4.c1.state", 32'(state_out), 32'h0);
      next_cycle();
      mem_busy = 1'b1; select_new_pc = 1'b1;
      settle();
      chk("t4.c2.state", 32'(state_out), 32'h2);
      chk_ctl("t4.c2", 1'b0, 1'b1, 1'b0, 1'b0);
      next_cycle();
      mem_busy = 1'b1;
      settle();
      chk_ctl("t4.c3", 1'b0, 1'b1, 1'b0, 1'b0);
      next_cycle();
      settle();
      chk("t4.rel.state", 32'(state_out), 32'h2);
      chk_ctl("t4.rel", 1'b1, 1'b0, 1'b1, 1'b1);
      next_cycle();
      settle();
      chk("t4.fl.state", 32'(state_out), 32'h1);
      chk("t4.fl.gflush", 32'(general_flush), 32'h1);
      chk("t4.flush_count", 32'(flush_count), 32'h1);
      chk("t4.stall_count", 32'(stall_count), 32'h3);
      next_cycle();
      settle();
      chk("t4.end.state", 32'(state_out), 32'h0);
      chk("t4.end.gflush", 32'(general_flush), 32'h0);

      // 5) hazard + redirect -> flush only; hazard + mem_busy -> freeze without bubble
      next_cycle();
      id_ex_mem_data_rd_en = 1'b1; id_ex_reg_wr_addr = 5'd9;
      if_id_rd_reg_a_en = 1'b1; if_id_rd_reg_a_addr = 5'd9;
      select_new_pc = 1'b1;
      settle();
      chk_ctl("t5.hz_br", 1'b1, 1'b0, 1'b1, 1'b1);
      next_cycle();
      id_ex_mem_data_rd_en = 1'b1; id_ex_reg_wr_addr = 5'd9;
      if_id_rd_reg_a_en = 1'b1; if_id_rd_reg_a_addr = 5'd9;
      settle();
      chk_ctl("t5.flush_ign_hz", 1'b1, 1'b0, 1'b1, 1'b1);
      next_cycle();
      settle();
      chk("t5.run.state", 32'(state_out), 32'h0);
      id_ex_mem_data_rd_en = 1'b1; id_ex_reg_wr_addr = 5'd9;
      if_id_rd_reg_a_en = 1'b1; if_id_rd_reg_a_addr = 5'd9;
      mem_busy = 1'b1;
      settle();
      chk_ctl("t5.hz_busy", 1'b0, 1'b1, 1'b0, 1'b0);
      next_cycle();
      settle();
      chk("t5.wait.state", 32'(state_out), 32'h2);
      chk_ctl("t5.release", 1'b1, 1'b0, 1'b0, 1'b0);
      next_cycle();
      settle();
      chk("t5.end.state", 32'(state_out), 32'h0);

      // 6) async reset in the middle of a flush
      next_cycle();
      select_new_pc = 1'b1;
      next_cycle();
      settle();
      chk("t6.in_flush", 32'(state_out), 32'h1);
      rst_n = 1'b0;
      settle();
      chk("t6.rst.state", 32'(state_out), 32'h0);
      chk_ctl("t6.rst", 1'b0, 1'b0, 1'b0, 1'b0);
      chk("t6.rst.flush_count", 32'(flush_count), 32'h0);
      next_cycle();
      rst_n = 1'b1;
      settle();
      chk_ctl("t6.after_rst", 1'b1, 1'b0, 1'b0, 1'b0);

      // stall_count saturation under a long memory wait
      for (int i = 0; i < 65534; i++) begin
         next_cycle();
         mem_busy = 1'b1;
      end
      next_cycle();
      mem_busy = 1'b1;
      settle();
      chk("sat.fffe", 32'(stall_count), 32'h0000fffe);
      next_cycle();
      mem_busy = 1'b1;
      settle();
      chk("sat.ffff", 32'(stall_count), 32'h0000ffff);
      for (int i = 0; i < 4; i++) begin
         next_cycle();
         mem_busy = 1'b1;
      end
      settle();
      chk("sat.hold", 32'(stall_count), 32'h0000ffff);
      counters_clr = 1'b1;
      next_cycle();
      mem_busy = 1'b1;
      settle();
      chk("sat.clr", 32'(stall_count), 32'h0);
      next_cycle();
      settle();
      chk("sat.release.state", 32'(state_out), 32'h2);
      chk("sat.release.inst", 32'(inst_rd_en), 32'h1);
      next_cycle();
      settle();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
